// File: rtl/cpu_mem_loader.sv
// Host-side loader for the cpu: writes/reads the instruction and data memories
// through their external ports, and runs the cpu for a programmed number of cycles.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for a command (cmd_ready high unless done is pulsing)
// WRITE  | selected wen asserted for one cycle with captured addr/data
// READ   | selected ren asserted for one cycle
// RWAIT  | waiting out the remaining RD_LAT-1 cycles of read latency
// RESP   | rsp_valid held with captured data until rsp_ready
// RUN    | cpu_enable high, run counter decrementing
module cpu_mem_loader #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [63:0] cmd_addr,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    input  logic        abort,
    output logic        done,
    output logic        err,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    input  logic [31:0] rdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2
);

    localparam logic [2:0] OP_WR_IMEM = 3'd0;
    localparam logic [2:0] OP_WR_DMEM = 3'd1;
    localparam logic [2:0] OP_RD_IMEM = 3'd2;
    localparam logic [2:0] OP_RD_DMEM = 3'd3;
    localparam logic [2:0] OP_RUN     = 3'd4;

    // Latency counter only has to hold RD_LAT-2 down to 0.
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_RESP,
        S_RUN
    } state_t;

    state_t             state, nxt_state;
    logic [2:0]         op_q, nxt_op;
    logic [CNT_W-1:0]   cnt, nxt_cnt;
    logic [LAT_W-1:0]   lat_cnt, nxt_lat;
    logic [63:0]        rd_word;
    logic               hold_addr;

    logic               nxt_cmd_ready, nxt_rsp_valid, nxt_done, nxt_err, nxt_cpu_enable;
    logic [63:0]        nxt_rsp_data;
    logic [63:0]        nxt_addr_ext, nxt_addr_ext_2, nxt_wdata_ext_2;
    logic [31:0]        nxt_wdata_ext;
    logic               nxt_wen_ext, nxt_ren_ext, nxt_wen_ext_2, nxt_ren_ext_2;

    assign rd_word = (op_q == OP_RD_IMEM) ? {32'b0, rdata_ext} : rdata_ext_2;

    // Next-state and next-output decode; all outputs are registered from these.
    always_comb begin
        nxt_state       = state;
        nxt_op          = op_q;
        nxt_cnt         = cnt;
        nxt_lat         = lat_cnt;
        nxt_rsp_valid   = 1'b0;
        nxt_rsp_data    = rsp_data;
        nxt_done        = 1'b0;
        nxt_err         = err;
        nxt_cpu_enable  = 1'b0;
        nxt_addr_ext    = '0;
        nxt_wen_ext     = 1'b0;
        nxt_ren_ext     = 1'b0;
        nxt_wdata_ext   = '0;
        nxt_addr_ext_2  = '0;
        nxt_wen_ext_2   = 1'b0;
        nxt_ren_ext_2   = 1'b0;
        nxt_wdata_ext_2 = '0;
        hold_addr       = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    nxt_op = cmd_op;
                    case (cmd_op)
                        OP_WR_IMEM: begin
                            nxt_state     = S_WRITE;
                            nxt_wen_ext   = 1'b1;
                            nxt_addr_ext  = cmd_addr;
                            nxt_wdata_ext = cmd_data[31:0];
                        end
                        OP_WR_DMEM: begin
                            nxt_state       = S_WRITE;
                            nxt_wen_ext_2   = 1'b1;
                            nxt_addr_ext_2  = cmd_addr;
                            nxt_wdata_ext_2 = cmd_data;
                        end
                        OP_RD_IMEM: begin
                            nxt_state    = S_READ;
                            nxt_ren_ext  = 1'b1;
                            nxt_addr_ext = cmd_addr;
                        end
                        OP_RD_DMEM: begin
                            nxt_state      = S_READ;
                            nxt_ren_ext_2  = 1'b1;
                            nxt_addr_ext_2 = cmd_addr;
                        end
                        OP_RUN: begin
                            nxt_cnt = cmd_data[CNT_W-1:0];
                            if (cmd_data[CNT_W-1:0] == '0) begin
                                nxt_done = 1'b1;
                            end else begin
                                nxt_state      = S_RUN;
                                nxt_cpu_enable = 1'b1;
                            end
                        end
                        default: nxt_err = 1'b1;
                    endcase
                end
            end
            S_WRITE: nxt_state = S_IDLE;
            S_READ: begin
                if (RD_LAT == 1) begin
                    nxt_state     = S_RESP;
                    nxt_rsp_valid = 1'b1;
                    nxt_rsp_data  = rd_word;
                end else begin
                    nxt_state = S_RWAIT;
                    nxt_lat   = LAT_W'(RD_LAT - 2);
                    hold_addr = 1'b1;
                end
            end
            S_RWAIT: begin
                if (lat_cnt == '0) begin
                    nxt_state     = S_RESP;
                    nxt_rsp_valid = 1'b1;
                    nxt_rsp_data  = rd_word;
                end else begin
                    nxt_lat   = lat_cnt - 1'b1;
                    hold_addr = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    nxt_state = S_IDLE;
                end else begin
                    nxt_rsp_valid = 1'b1;
                end
            end
            S_RUN: begin
                if (cnt == CNT_W'(1) || abort) begin
                    nxt_state = S_IDLE;
                    nxt_done  = 1'b1;
                    nxt_cnt   = '0;
                end else begin
                    nxt_cnt        = cnt - 1'b1;
                    nxt_cpu_enable = 1'b1;
                end
            end
            default: nxt_state = S_IDLE;
        endcase

        // The read address stays on the selected port until the data is captured.
        if (hold_addr) begin
            if (op_q == OP_RD_IMEM) nxt_addr_ext   = addr_ext;
            else                    nxt_addr_ext_2 = addr_ext_2;
        end

        // No new command is taken in the cycle done is pulsing.
        nxt_cmd_ready = (nxt_state == S_IDLE) && !nxt_done;
    end

    // State, capture and registered outputs.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            op_q        <= '0;
            cnt         <= '0;
            lat_cnt     <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            cpu_enable  <= 1'b0;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            ren_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            ren_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
        end else begin
            state       <= nxt_state;
            op_q        <= nxt_op;
            cnt         <= nxt_cnt;
            lat_cnt     <= nxt_lat;
            cmd_ready   <= nxt_cmd_ready;
            rsp_valid   <= nxt_rsp_valid;
            rsp_data    <= nxt_rsp_data;
            done        <= nxt_done;
            err         <= nxt_err;
            cpu_enable  <= nxt_cpu_enable;
            addr_ext    <= nxt_addr_ext;
            wen_ext     <= nxt_wen_ext;
            ren_ext     <= nxt_ren_ext;
            wdata_ext   <= nxt_wdata_ext;
            addr_ext_2  <= nxt_addr_ext_2;
            wen_ext_2   <= nxt_wen_ext_2;
            ren_ext_2   <= nxt_ren_ext_2;
            wdata_ext_2 <= nxt_wdata_ext_2;
        end
    end

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Bench for cpu_mem_loader: two instances (RD_LAT=1 and RD_LAT=2) share the
// command channel; response and write-port activity go through scoreboards.
module tb_cpu_mem_loader;

    localparam logic [2:0] OP_WR_IMEM = 3'd0;
    localparam logic [2:0] OP_WR_DMEM = 3'd1;
    localparam logic [2:0] OP_RD_IMEM = 3'd2;
    localparam logic [2:0] OP_RD_DMEM = 3'd3;
    localparam logic [2:0] OP_RUN     = 3'd4;

    typedef struct {
        logic        dmem;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk, arst;
    logic        cmd_valid, rsp_ready, abort;
    logic [2:0]  cmd_op;
    logic [63:0] cmd_addr, cmd_data;

    logic        cmd_ready, rsp_valid, done, err, cpu_enable;
    logic [63:0] rsp_data, addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext, rdata_ext;

    logic        cmd_ready2, rsp_valid2, done2, err2, cpu_enable2;
    logic [63:0] rsp_data2, addr2_ext, addr2_ext_2, wdata2_ext_2, rdata2_ext_2;
    logic        wen2_ext, ren2_ext, wen2_ext_2, ren2_ext_2;
    logic [31:0] wdata2_ext, rdata2_ext;

    logic [31:0] imem  [32];
    logic [63:0] dmem  [32];
    logic [31:0] imem2 [32];
    logic [63:0] dmem2 [32];

    logic [63:0] rq [$];
    logic [63:0] rq2 [$];
    wr_t         wq [$];
    wr_t         w;

    int checks = 0;
    int errors = 0;

    cpu_mem_loader #(.RD_LAT(1), .CNT_W(32)) u_dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .abort(abort), .done(done), .err(err), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    cpu_mem_loader #(.RD_LAT(2), .CNT_W(32)) u_dut2 (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2),
        .abort(abort), .done(done2), .err(err2), .cpu_enable(cpu_enable2),
        .addr_ext(addr2_ext), .wen_ext(wen2_ext), .ren_ext(ren2_ext),
        .wdata_ext(wdata2_ext), .rdata_ext(rdata2_ext),
        .addr_ext_2(addr2_ext_2), .wen_ext_2(wen2_ext_2), .ren_ext_2(ren2_ext_2),
        .wdata_ext_2(wdata2_ext_2), .rdata_ext_2(rdata2_ext_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: synchronous write, read data follows the presented address.
    always @(posedge clk) begin
        if (wen_ext)    imem[addr_ext[6:2]]     <= wdata_ext;
        if (wen_ext_2)  dmem[addr_ext_2[7:3]]   <= wdata_ext_2;
        if (wen2_ext)   imem2[addr2_ext[6:2]]   <= wdata2_ext;
        if (wen2_ext_2) dmem2[addr2_ext_2[7:3]] <= wdata2_ext_2;
    end
    assign rdata_ext    = imem[addr_ext[6:2]];
    assign rdata_ext_2  = dmem[addr_ext_2[7:3]];
    assign rdata2_ext   = imem2[addr2_ext[6:2]];
    assign rdata2_ext_2 = dmem2[addr2_ext_2[7:3]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] d);
        int n;
        n = 0;
        while (!(cmd_ready && cmd_ready2) && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: ready=%b/%b, expected 1/1", cmd_ready, cmd_ready2);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        tick(1);
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic monitor_cycle();
        if (rsp_valid && rsp_ready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %h, expected no response", rsp_data);
            end else chk("rsp_data", rsp_data, rq.pop_front());
        end
        if (rsp_valid2 && rsp_ready) begin
            if (rq2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp2_unexpected: got %h, expected no response", rsp_data2);
            end else chk("rsp2_data", rsp_data2, rq2.pop_front());
        end
        if (wen_ext || wen_ext_2) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got wen=%b/%b, expected none", wen_ext, wen_ext_2);
            end else begin
                w = wq.pop_front();
                chk("wr_sel", {62'b0, wen_ext, wen_ext_2}, w.dmem ? 64'd1 : 64'd2);
                chk("wr_addr", w.dmem ? addr_ext_2 : addr_ext, w.addr);
                chk("wr_data", w.dmem ? wdata_ext_2 : {32'b0, wdata_ext}, w.data);
                chk("wr_unsel_zero", w.dmem ? (addr_ext | {32'b0, wdata_ext} | {63'b0, ren_ext})
                                            : (addr_ext_2 | wdata_ext_2 | {63'b0, ren_ext_2}), 64'd0);
            end
        end
        if (cpu_enable) begin
            chk("run_ports_quiet", {60'b0, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 64'd0);
        end
    endtask

    task automatic stimulus();
        // Reset state
        tick(3);
        arst = 1'b0;
        tick(1);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ctrl_zero", {rsp_valid, done, err, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
        chk("rst_bus_zero", addr_ext | addr_ext_2 | wdata_ext_2 | {32'b0, wdata_ext} | rsp_data, 0);

        // WR_IMEM 0x8 <- 0x13
        wq.push_back('{dmem: 1'b0, addr: 64'h8, data: 64'h13});
        send(OP_WR_IMEM, 64'h8, 64'h0000_0013);
        chk("wr_wen_t1", wen_ext, 1);
        chk("wr_ready_t1", cmd_ready, 0);
        tick(1);
        chk("wr_wen_t2", wen_ext, 0);
        chk("wr_ready_t2", cmd_ready, 1);
        chk("wr_addr_idle", addr_ext, 0);
        chk("wr_no_enable", cpu_enable, 0);

        // WR_DMEM then RD_DMEM with a 3-cycle rsp_ready stall
        wq.push_back('{dmem: 1'b1, addr: 64'h10, data: 64'hDEADBEEF_CAFEF00D});
        send(OP_WR_DMEM, 64'h10, 64'hDEADBEEF_CAFEF00D);
        tick(1);
        rsp_ready = 1'b0;
        rq.push_back(64'hDEADBEEF_CAFEF00D);
        rq2.push_back(64'hDEADBEEF_CAFEF00D);
        send(OP_RD_DMEM, 64'h10, 64'h0);
        chk("rd_ren2_t1", ren_ext_2, 1);
        chk("rd_addr2_t1", addr_ext_2, 64'h10);
        chk("rd_valid_t1", rsp_valid, 0);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_data, 64'hDEADBEEF_CAFEF00D);
            tick(1);
        end
        rsp_ready = 1'b1;
        tick(1);
        chk("rd_valid_after_hs", rsp_valid, 0);
        chk("rd_ready_after_hs", cmd_ready, 1);

        // RD_IMEM latency on both instances
        wq.push_back('{dmem: 1'b0, addr: 64'h20, data: 64'h0050_0093});
        send(OP_WR_IMEM, 64'h20, 64'h0000_0000_0050_0093);
        rq.push_back(64'h0000_0000_0050_0093);
        rq2.push_back(64'h0000_0000_0050_0093);
        send(OP_RD_IMEM, 64'h20, 64'h0);
        chk("rdi_ren_t1", ren_ext, 1);
        chk("rdi_valid_t1", {rsp_valid, rsp_valid2}, 2'b00);
        tick(1);
        chk("rdi_valid_t2", {rsp_valid, rsp_valid2}, 2'b10);
        tick(1);
        chk("rdi_valid_t3", {rsp_valid, rsp_valid2}, 2'b01);
        chk("rdi_ready_t3", cmd_ready, 1);
        tick(1);
        chk("rdi_valid_t4", {rsp_valid, rsp_valid2}, 2'b00);

        // RUN N=5
        send(OP_RUN, 64'h0, 64'd5);
        for (int i = 1; i <= 5; i++) begin
            chk("run5_enable", cpu_enable, 1);
            chk("run5_no_done", done, 0);
            tick(1);
        end
        chk("run5_enable_off", cpu_enable, 0);
        chk("run5_done", done, 1);
        chk("run5_ready_busy", cmd_ready, 0);
        tick(1);
        chk("run5_done_off", done, 0);
        chk("run5_ready", cmd_ready, 1);

        // RUN N=0
        send(OP_RUN, 64'h0, 64'd0);
        chk("run0_done", done, 1);
        chk("run0_enable", cpu_enable, 0);
        tick(1);
        chk("run0_done_off", done, 0);
        chk("run0_ready", {cmd_ready, cpu_enable}, 2'b10);

        // RUN N=100 aborted on the 3rd enabled cycle
        send(OP_RUN, 64'h0, 64'd100);
        chk("abort_en1", cpu_enable, 1);
        tick(1);
        chk("abort_en2", cpu_enable, 1);
        tick(1);
        chk("abort_en3", cpu_enable, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_enable_off", cpu_enable, 0);
        chk("abort_done", done, 1);
        tick(1);
        chk("abort_done_off", done, 0);
        chk("abort_ready", cmd_ready, 1);

        // Async reset during RUN
        send(OP_RUN, 64'h0, 64'd50);
        tick(2);
        chk("arst_pre_enable", cpu_enable, 1);
        #2;
        arst = 1'b1;
        #1;
        chk("arst_enable_async", cpu_enable, 0);
        @(posedge clk);
        #1;
        arst = 1'b0;
        tick(1);
        chk("arst_ready", cmd_ready, 1);
        chk("arst_quiet", {cpu_enable, done, rsp_valid}, 3'b000);

        // Illegal opcode: sticky err, no response, later commands still work
        send(3'd7, 64'h40, 64'h1234);
        chk("illegal_err", err, 1);
        chk("illegal_ready", cmd_ready, 1);
        chk("illegal_no_rsp", rsp_valid, 0);
        wq.push_back('{dmem: 1'b0, addr: 64'h30, data: 64'h00A0_0113});
        send(OP_WR_IMEM, 64'h30, 64'h00A0_0113);
        chk("illegal_next_wen", wen_ext, 1);
        chk("illegal_err_sticky1", err, 1);
        rq.push_back(64'h00A0_0113);
        rq2.push_back(64'h00A0_0113);
        send(OP_RD_IMEM, 64'h30, 64'h0);
        tick(5);
        chk("illegal_err_sticky2", err, 1);
        chk("rq_drained", rq.size(), 0);
        chk("rq2_drained", rq2.size(), 0);
        chk("wq_drained", wq.size(), 0);
    endtask

    initial begin
        arst      = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
        rsp_ready = 1'b1;
        abort     = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (!arst) monitor_cycle();
                end
            end
            begin
                stimulus();
            end
            begin
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog: stimulus still running after 20000 cycles, expected completion");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
